// File: rtl/edge_event_scheduler.sv
// Rising-edge detector bank feeding a round-robin scheduler for one shared service unit.
// One request is in flight at a time: offer, wait for completion, then hold an idle gap.
module edge_event_scheduler #(
    parameter int unsigned N   = 4,
    parameter int unsigned GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         signal_in,
    input  logic                 svc_ready,
    input  logic                 svc_done,
    input  logic [N-1:0]         ovf_clr,
    output logic                 svc_valid,
    output logic [$clog2(N)-1:0] svc_id,
    output logic [N-1:0]         pending,
    output logic [N-1:0]         overflow,
    output logic                 busy
);
    localparam int unsigned IDW = $clog2(N);
    localparam int unsigned CW  = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP_ST} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [IDW-1:0] last, last_n, id_n, pick;
    logic [N-1:0]   signal_d, rise, acc_mask;
    logic           accept;

    assign rise     = signal_in & ~signal_d;
    assign accept   = svc_valid & svc_ready;
    assign acc_mask = accept ? (N'(1) << svc_id) : '0;

    // Round-robin search starting just after the last granted channel; lowest offset wins.
    always_comb begin
        pick = last;
        for (int unsigned k = N; k >= 1; k--) begin
            if (pending[IDW'((32'(last) + k) % N)]) begin
                pick = IDW'((32'(last) + k) % N);
            end
        end
    end

    // A new rise beats a same-cycle acceptance; overflow set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signal_d <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            signal_d <= signal_in;
            pending  <= (pending & ~acc_mask) | rise;
            overflow <= (overflow & ~ovf_clr) | (rise & pending & ~acc_mask);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        id_n    = svc_id;
        unique case (state)
            IDLE: begin
                if (|pending) begin
                    state_n = ISSUE;
                    id_n    = pick;
                    last_n  = pick;
                end
            end
            ISSUE: begin
                if (svc_ready) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (svc_done) begin
                    if (GAP == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = GAP_ST;
                        cnt_n   = CW'(GAP - 1);
                    end
                end
            end
            GAP_ST: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they track state exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= IDW'(N - 1);
            svc_id    <= '0;
            svc_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last      <= last_n;
            svc_id    <= id_n;
            svc_valid <= (state_n == ISSUE);
            busy      <= (state_n != IDLE);
        end
    end
endmodule
